// File: rtl/distram_delay_pkg.sv
// Shared widths and FSM state encoding for the distributed-RAM delay line controller.
// No logic; constants and types only.
// Imported by the controller and its testbench.
package distram_delay_pkg;

    localparam int DELAY_W = 5;
    localparam int ADDR_W  = 5;

    // FILL: RAM still holds data from before the last reload; RUN: read side is valid.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/distram_delay_ctrl.sv
// Address/valid controller for a RAM-based delay line: write pointer leads read pointer by cur_delay.
// Latency: all outputs registered; ack/err appear the cycle after the request edge, data valid after delay+1 cycles.
// Backpressure: none; a request is accepted or rejected on the edge it is sampled, every cycle.
module distram_delay_ctrl
    import distram_delay_pkg::*;
#(
    parameter logic [DELAY_W-1:0] DEFAULT_DELAY = 5'd5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [DELAY_W-1:0] delay_i,
    input  logic               delay_req_i,
    output logic               delay_ack_o,
    output logic               delay_err_o,
    output logic [ADDR_W-1:0]  wraddr_o,
    output logic [ADDR_W-1:0]  rdaddr_o,
    output logic               dat_valid_o,
    output logic [DELAY_W-1:0] cur_delay_o
);

    // Declaration initialisers give power-up values identical to the reset values.
    state_t             state_q     = FILL;
    logic [DELAY_W-1:0] fill_cnt_q  = '0;
    logic [ADDR_W-1:0]  wraddr_q    = ADDR_W'(DEFAULT_DELAY);
    logic [ADDR_W-1:0]  rdaddr_q    = '0;
    logic [DELAY_W-1:0] cur_delay_q = DEFAULT_DELAY;
    logic               dat_valid_q = 1'b0;
    logic               ack_q       = 1'b0;
    logic               err_q       = 1'b0;

    state_t             state_d;
    logic [DELAY_W-1:0] fill_cnt_d;
    logic [ADDR_W-1:0]  wraddr_d;
    logic [ADDR_W-1:0]  rdaddr_d;
    logic [DELAY_W-1:0] cur_delay_d;
    logic               dat_valid_d;
    logic               ack_d;
    logic               err_d;
    logic               accept;

    // Next-state: reload on an accepted request, otherwise advance pointers and the fill count.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        wraddr_d    = wraddr_q;
        rdaddr_d    = rdaddr_q;
        cur_delay_d = cur_delay_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        accept      = delay_req_i && (delay_i != '0);

        if (accept) begin
            // Restarting both pointers keeps wraddr - rdaddr == cur_delay by construction.
            rdaddr_d    = '0;
            wraddr_d    = ADDR_W'(delay_i);
            cur_delay_d = delay_i;
            fill_cnt_d  = '0;
            state_d     = FILL;
            ack_d       = 1'b1;
        end else begin
            rdaddr_d = rdaddr_q + ADDR_W'(1);
            wraddr_d = wraddr_q + ADDR_W'(1);
            err_d    = delay_req_i;
            if (state_q == FILL) begin
                // Count holds once RUN is reached; it is only meaningful during FILL.
                if (fill_cnt_q == cur_delay_q) begin
                    state_d = RUN;
                end else begin
                    fill_cnt_d = fill_cnt_q + DELAY_W'(1);
                end
            end
        end

        // Valid is a registered copy of the next state so it lines up with the RAM output register.
        dat_valid_d = (state_d == RUN);
    end

    // State and output registers with synchronous reset taking priority over any request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            wraddr_q    <= ADDR_W'(DEFAULT_DELAY);
            rdaddr_q    <= '0;
            cur_delay_q <= DEFAULT_DELAY;
            dat_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            wraddr_q    <= wraddr_d;
            rdaddr_q    <= rdaddr_d;
            cur_delay_q <= cur_delay_d;
            dat_valid_q <= dat_valid_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    assign delay_ack_o = ack_q;
    assign delay_err_o = err_q;
    assign wraddr_o    = wraddr_q;
    assign rdaddr_o    = rdaddr_q;
    assign dat_valid_o = dat_valid_q;
    assign cur_delay_o = cur_delay_q;

endmodule

// File: tb/tb_distram_delay_ctrl.sv
// Scoreboard bench for distram_delay_ctrl: driver pushes expected outputs per cycle, monitor compares.
// Expected values follow "cycle N after reload": rd=N, wr=D+N (mod 32), valid iff N>=D+1.
// Monitor samples on the falling edge; driver changes inputs just after the rising edge.
module tb_distram_delay_ctrl;
    import distram_delay_pkg::*;

    logic               clk_i = 1'b1;
    logic               rst_i;
    logic [DELAY_W-1:0] delay_i;
    logic               delay_req_i;
    logic               delay_ack_o;
    logic               delay_err_o;
    logic [ADDR_W-1:0]  wraddr_o;
    logic [ADDR_W-1:0]  rdaddr_o;
    logic               dat_valid_o;
    logic [DELAY_W-1:0] cur_delay_o;

    distram_delay_ctrl #(.DEFAULT_DELAY(5'd5)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .delay_i     (delay_i),
        .delay_req_i (delay_req_i),
        .delay_ack_o (delay_ack_o),
        .delay_err_o (delay_err_o),
        .wraddr_o    (wraddr_o),
        .rdaddr_o    (rdaddr_o),
        .dat_valid_o (dat_valid_o),
        .cur_delay_o (cur_delay_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       ack;
        logic       err;
        logic       vld;
        logic [4:0] wr;
        logic [4:0] rd;
        logic [4:0] cur;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference state: delay in effect and cycles elapsed since the last reload.
    int   m_d   = 5;
    int   m_n   = 0;
    logic m_ack = 1'b0;
    logic m_err = 1'b0;

    function automatic exp_t make_exp(input int d, input int n, input logic ack, input logic err);
        exp_t e;
        e.ack = ack;
        e.err = err;
        e.vld = (n >= d + 1);
        e.rd  = 5'(n % 32);
        e.wr  = 5'((d + n) % 32);
        e.cur = 5'(d);
        return e;
    endfunction

    // One clock of stimulus, then push what the outputs must show during the following cycle.
    task automatic tick(input logic rst, input logic req, input logic [4:0] d);
        rst_i       = rst;
        delay_req_i = req;
        delay_i     = d;
        @(posedge clk_i);
        #1;
        if (rst) begin
            m_d = 5; m_n = 0; m_ack = 1'b0; m_err = 1'b0;
        end else if (req && d != 5'd0) begin
            m_d = int'(d); m_n = 0; m_ack = 1'b1; m_err = 1'b0;
        end else begin
            m_n = m_n + 1; m_ack = 1'b0; m_err = req;
        end
        exp_q.push_back(make_exp(m_d, m_n, m_ack, m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 5'd0);
    endtask

    // Monitor: every cycle the DUT presents a full output vector; compare it against the scoreboard.
    always @(negedge clk_i) begin
        exp_t        e;
        logic [4:0]  diff;
        diff = wraddr_o - rdaddr_o;
        n_cmp++;
        assert (diff == cur_delay_o)
        else begin
            n_bad++;
            $display("FAIL invariant cyc=%0d wr-rd=%0d cur_delay=%0d", cyc, diff, cur_delay_o);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (delay_ack_o !== e.ack || delay_err_o !== e.err || dat_valid_o !== e.vld ||
                wraddr_o !== e.wr || rdaddr_o !== e.rd || cur_delay_o !== e.cur) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d got ack=%b err=%b vld=%b wr=%0d rd=%0d cur=%0d want ack=%b err=%b vld=%b wr=%0d rd=%0d cur=%0d",
                         cyc, delay_ack_o, delay_err_o, dat_valid_o, wraddr_o, rdaddr_o, cur_delay_o,
                         e.ack, e.err, e.vld, e.wr, e.rd, e.cur);
            end
        end
        cyc++;
    end

    initial begin
        rst_i       = 1'b0;
        delay_req_i = 1'b0;
        delay_i     = 5'd0;
        // Power-up values, checked before the first clock edge.
        exp_q.push_back(make_exp(5, 0, 1'b0, 1'b0));

        // Reset then free-run with the default delay through a full address wrap.
        tick(1'b1, 1'b0, 5'd0);
        tick(1'b1, 1'b0, 5'd0);
        idle(40);

        // Reload to 12 while running.
        tick(1'b0, 1'b1, 5'd12);
        idle(15);

        // Zero delay request in RUN is rejected without disturbing anything.
        tick(1'b0, 1'b1, 5'd0);
        idle(3);

        // Reload to 20, then restart with 3 during FILL cycle 7.
        tick(1'b0, 1'b1, 5'd20);
        idle(7);
        tick(1'b0, 1'b1, 5'd3);
        idle(6);

        // Same delay again still reloads.
        tick(1'b0, 1'b1, 5'd3);
        idle(6);

        // Request held high for several cycles.
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 5'd7);
        idle(10);

        // Reset beats a simultaneous request.
        tick(1'b1, 1'b1, 5'd9);
        idle(8);

        // Extreme delays.
        tick(1'b0, 1'b1, 5'd31);
        idle(36);
        tick(1'b0, 1'b1, 5'd1);
        idle(4);

        // Reset in the middle of FILL, then a rejected request during FILL.
        tick(1'b0, 1'b1, 5'd10);
        idle(3);
        tick(1'b1, 1'b0, 5'd0);
        idle(2);
        tick(1'b0, 1'b1, 5'd0);
        idle(6);

        // Let the monitor drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk_i);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/distram_delay_ctrl.md
DISTRAM_DELAY_CTRL -- requirements
Module: distram_delay_ctrl

Interface
REQ-001 Parameter: DEFAULT_DELAY, 5'd5, delay loaded at reset; total latency through RAM plus output register = delay+1 clocks.
REQ-002 Port: clk_i  input  1  sole clock; all logic on rising edge.
REQ-003 Port: rst_i  input  1  reset, synchronous, active-high.
REQ-004 Port: delay_i  input  5  requested delay (legal 1..31).
REQ-005 Port: delay_req_i  input  1  request to apply delay_i; sampled each clock.
REQ-006 Port: delay_ack_o  output  1  one-cycle pulse: request accepted.
REQ-007 Port: delay_err_o  output  1  one-cycle pulse: request rejected (delay_i==0).
REQ-008 Port: wraddr_o  output  5  RAM write address, registered.
REQ-009 Port: rdaddr_o  output  5  RAM read address, registered.
REQ-010 Port: dat_valid_o  output  1  high when the registered RAM output holds data written under the current delay.
REQ-011 Port: cur_delay_o  output  5  delay currently in effect.

Function
REQ-012 States: FILL, RUN; reset enters FILL.
REQ-013 Every non-reset cycle, wraddr_o and rdaddr_o each increment by 1 mod 32, except on an accepted request.
REQ-014 Request accepted when delay_req_i=1 and delay_i!=0, in either state; the same edge sets rdaddr_o=0, wraddr_o=delay_i, cur_delay_o=delay_i, fill counter=0, state=FILL.
REQ-015 delay_ack_o=1 in the cycle after the accepting edge; otherwise 0.
REQ-016 delay_req_i=1 with delay_i=0: no state or address change; delay_err_o=1 in the following cycle.
REQ-017 Invariant: wraddr_o - rdaddr_o == cur_delay_o (mod 32) in every cycle.
REQ-018 FILL: counter increments each cycle; when counter reaches cur_delay_o, next edge enters RUN.
REQ-019 dat_valid_o is registered, =1 exactly in RUN; cycle N after reload (N=0 is first cycle with rdaddr_o=0) has dat_valid_o=1 iff N >= cur_delay_o+1.
REQ-020 A request accepted during FILL restarts FILL from counter 0 with the new delay; no valid cycle in between.
REQ-021 A request repeating the current delay is still accepted and restarts FILL.
REQ-022 Address wrap 31->0 is seamless; no effect on state or dat_valid_o.
REQ-023 delay_req_i held high: re-accepted every cycle; dat_valid_o stays 0, ack stays 1.

Reset
REQ-024 rst_i wins over a simultaneous delay_req_i.
REQ-025 Reset values: rdaddr_o=0, wraddr_o=DEFAULT_DELAY, cur_delay_o=DEFAULT_DELAY, dat_valid_o=0, delay_ack_o=0, delay_err_o=0, state=FILL, counter=0.
REQ-026 Reset mid-FILL or mid-RUN discards any pending/accepted request; the fill sequence restarts with DEFAULT_DELAY.
REQ-027 All registers have power-up initial values equal to their reset values.

Structure
REQ-028 Package distram_delay_pkg holds DELAY_W=5, ADDR_W=5, and the state enum typedef (FILL, RUN).
REQ-029 No sub-module; one FSM plus address and fill counters in one module, driving external RAM-delay datapath address ports.
REQ-030 Implementation 120-400 lines; no combinational path from inputs to outputs.

Verification
REQ-031 Reset, no requests -> wraddr_o=5, rdaddr_o=0 at cycle 0; dat_valid_o rises at cycle 6 and stays high; difference 5 through 40 cycles including wrap.
REQ-032 In RUN, delay_i=12 with one-cycle req -> next cycle ack=1, rdaddr_o=0, wraddr_o=12, dat_valid_o=0; dat_valid_o=1 from cycle 13.
REQ-033 delay_i=0 request in RUN -> err=1 one cycle, no ack, addresses keep incrementing, dat_valid_o stays 1.
REQ-034 Request delay 20 then, at FILL cycle 7, request delay 3 -> refill to 3, dat_valid_o=1 at cycle 4 after second reload, never high between.
REQ-035 rst_i and delay_req_i (delay 9) same cycle -> reset values, no ack, delay stays 5.
REQ-036 Delay 31 -> wraddr_o=31 at reload, valid at cycle 32; delay 1 -> valid at cycle 2; invariant REQ-017 checked every cycle by assertion.
